beta_mem_stall: RTL and testbench
=================================

# beta_mem_stall

Parametrised memory stage for the pipelined Beta. Holds the MEM-stage pipeline registers (PC, IR, Y, D) and drives the data-memory port. Unlike the fixed single-cycle stage, it talks to a variable-latency memory through an acknowledge handshake. It stalls the upstream pipeline while an access is outstanding, aborts hung accesses after a bounded wait, and hands registered load data to write-back.

## Interface
- `W`, 32: datapath width (PC, IR, Y, D, memory data and address); must be ≥ 32.
- `MAX_WAIT`, 15: wait cycles without `mack` before an access is aborted; must be ≥ 1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `irsrc` in 2: IR source select; 0 = `irin`, 1 = BNE trap word, 2/3 = NOP.
- `pcin`, `irin`, `yin`, `din` in W each: values arriving from the ALU stage.
- `pcout`, `irout`, `yout` out W each: current stage registers, passed to write-back.
- `rdout` out W: load data of the instruction that last left this stage.
- `maddr` out W: equals Y.
- `mwd` out W: equals D.
- `mwr` out 1: write strobe.
- `moe` out 1: read strobe.
- `mack` in 1: memory completes the current access in this cycle.
- `mrd` in W: read data, valid when `mack`=1.
- `stall` out 1: upstream must hold; this stage ignores its inputs.
- `merr` out 1: one-cycle pulse on access timeout.

## Operation
- Opcode is `IR[31:26]` (full 6 bits).
  - ST = 6'b011001: `mwr`.
  - LD = 6'b011000 and LDR = 6'b011111: `moe`.
  - All other opcodes are non-memory.
- NOP word is 32'h83FFFFFF; BNE trap word is 32'h7BDFFFFF. Both are zero-extended when W > 32.
- `mem_op` = IR is LD, LDR or ST. `mwr` = ST and `moe` = LD|LDR, both gated only by `mem_op` and the state (below).
- FSM states are IDLE and WAIT. A wait counter `cnt` (ceil(log2(MAX_WAIT+1)) bits) runs alongside.
  - IDLE, with `mem_op` and `mack`=1: zero-wait completion. `stall`=0, stay in IDLE.
  - IDLE, with `mem_op` and `mack`=0: `stall`=1, go to WAIT with `cnt`=1.
  - IDLE, without `mem_op`: `stall`=0.
  - WAIT, `mack`=1: `stall`=0, go to IDLE, `cnt`=0.
  - WAIT, `mack`=0 and `cnt`<MAX_WAIT: `stall`=1, `cnt`++.
  - WAIT, `mack`=0 and `cnt`==MAX_WAIT: timeout. `merr`=1, `stall`=0, go to IDLE, `cnt`=0.
- `mwr`/`moe` stay high throughout the access, including the completing or timeout cycle. They fall only when IR changes.
- Advance edge (`stall`=0):
  - pc←`pcin`, y←`yin`, d←`din`.
  - IR is loaded per `irsrc`.
  - rd←`mrd` if the retiring IR is LD/LDR and `mack`=1; otherwise rd←0. A timed-out load gives rd=0.
- Stall edge (`stall`=1): pc, ir, y, d and rd all hold. `irsrc` is ignored, so trap/NOP injection waits until the access ends.
- `mack` while `mem_op`=0 is ignored and does not affect rd.

## Timing
- Reset values: pc=0, ir=NOP, y=0, d=0, rd=0, state IDLE, cnt=0.
  - Hence `pcout`=0, `irout`=NOP, `yout`=`maddr`=`mwd`=`rdout`=0.
  - `mwr`=`moe`=`stall`=`merr`=0 in the cycle after the reset edge.
- Reset wins over everything, including a pending access. An outstanding access is abandoned with no `merr`; the memory sees its strobes drop after the reset edge.
- `stall` and `merr` are combinational from state, `cnt`, IR and `mack`, with no registered delay. Upstream must sample `stall` in the same cycle.
- Latency:
  - Non-memory instruction: 1 cycle in this stage.
  - Access acknowledged after k wait cycles: k+1 cycles.
  - Timeout: MAX_WAIT+1 cycles.
- `rdout` becomes valid one edge after the load retires, aligned with the write-back register.
- Back-to-back memory ops: each re-enters IDLE and its handshake starts fresh. No `mack` is carried over.

## Test plan
- Reset with `irin`=LD held, then release:
  - Immediately after the reset edge: `irout`=NOP, all strobes 0, `rdout`=0.
  - After the first advance edge: IR=LD and `moe`=1.
- LD with `yin`=0x40, `mack`=1 in the same cycle, `mrd`=0xDEADBEEF:
  - `stall` never asserts.
  - `rdout`=0xDEADBEEF one edge later.
- ST with `yin`=0x80, `din`=0x1234, `mack` after 3 cycles:
  - `stall`=1 for exactly 3 cycles.
  - `maddr`=0x80, `mwd`=0x1234 and `mwr`=1 throughout.
  - PC, IR and Y hold during the stall even though `pcin`, `irin` and `yin` change.
- LD with `mack` never asserted, MAX_WAIT=15:
  - `stall` high for 15 cycles.
  - `merr` pulses for 1 cycle on the 16th.
  - Stage advances; `rdout`=0.
- `irsrc`=1 asserted during a stall:
  - IR is unchanged while `stall`=1.
  - `irsrc`=1 still held at the advance edge loads BNE (32'h7BDFFFFF).
  - `irsrc`=2 loads NOP.
- `reset` asserted in the middle of WAIT: next cycle `cnt`=0, `stall`=0, IR=NOP, `merr`=0.

Source files
------------

// File: rtl/beta_mem_stall.sv
// -----------------------------------------------------------------------------
// beta_mem_stall
//
// MEM stage of the pipelined Beta with a variable-latency data memory.
// Holds the stage registers (pc, ir, y, d), drives the memory port from them,
// and waits on the memory acknowledge before letting the instruction move on
// to write-back. Upstream is held off with a combinational stall. An access
// that never gets acknowledged is aborted after MAX_WAIT wait cycles, with a
// one-cycle error pulse.
//
// Parameters
//   W         datapath width (>= 32)
//   MAX_WAIT  wait cycles without mack before an access is aborted (>= 1)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   irsrc                   IR select: 0 = irin, 1 = BNE trap, 2/3 = NOP
//   pcin, irin, yin, din    values arriving from the ALU stage
//   pcout, irout, yout      stage registers, passed to write-back
//   rdout                   load data of the instruction that last left
//   maddr, mwd              memory address (= y) and write data (= d)
//   mwr, moe                write / read strobes
//   mack, mrd               memory acknowledge and read data
//   stall                   upstream must hold this cycle
//   merr                    one-cycle pulse on access timeout
// -----------------------------------------------------------------------------
module beta_mem_stall #(
    parameter int W        = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   irsrc,
    input  logic [W-1:0] pcin,
    input  logic [W-1:0] irin,
    input  logic [W-1:0] yin,
    input  logic [W-1:0] din,
    output logic [W-1:0] pcout,
    output logic [W-1:0] irout,
    output logic [W-1:0] yout,
    output logic [W-1:0] rdout,
    output logic [W-1:0] maddr,
    output logic [W-1:0] mwd,
    output logic         mwr,
    output logic         moe,
    input  logic         mack,
    input  logic [W-1:0] mrd,
    output logic         stall,
    output logic         merr
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    localparam logic [W-1:0] NOP_WORD = W'(32'h83FF_FFFF);
    localparam logic [W-1:0] BNE_WORD = W'(32'h7BDF_FFFF);

    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_LDR = 6'b011111;
    localparam logic [5:0] OP_ST  = 6'b011001;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic [W-1:0]   pc, ir, y, d, rd;
    logic [W-1:0]   ir_sel;

    logic [5:0]     opcode;
    logic           is_ld, is_st, mem_op;

    // Instruction decode on the held IR
    assign opcode = ir[31:26];
    assign is_ld  = (opcode == OP_LD) || (opcode == OP_LDR);
    assign is_st  = (opcode == OP_ST);
    assign mem_op = is_ld || is_st;

    // Strobes follow the IR for the whole access, including the completing
    // or timeout cycle; they only drop once a new IR is loaded.
    assign mwr   = is_st;
    assign moe   = is_ld;
    assign maddr = y;
    assign mwd   = d;

    assign pcout = pc;
    assign irout = ir;
    assign yout  = y;
    assign rdout = rd;

    // State register. The wait counter lives alongside the FSM state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_op && !mack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT: begin
                if (mack || (cnt >= MAX_CNT)) begin
                    // Completion or timeout: the next access starts fresh.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: purely combinational so upstream sees stall this cycle.
    always_comb begin
        stall = 1'b0;
        merr  = 1'b0;
        case (state)
            IDLE: stall = mem_op && !mack;
            WAIT: begin
                stall = !mack && (cnt < MAX_CNT);
                merr  = !mack && (cnt >= MAX_CNT);
            end
            default: ;
        endcase
    end

    // IR source mux; only consulted on an advance edge.
    always_comb begin
        case (irsrc)
            2'd0:    ir_sel = irin;
            2'd1:    ir_sel = BNE_WORD;
            default: ir_sel = NOP_WORD;
        endcase
    end

    // Pipeline registers: advance when not stalled, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            ir <= NOP_WORD;
            y  <= '0;
            d  <= '0;
            rd <= '0;
        end else if (!stall) begin
            pc <= pcin;
            ir <= ir_sel;
            y  <= yin;
            d  <= din;
            // A timed-out load has mack=0 here and therefore retires with 0.
            rd <= (is_ld && mack) ? mrd : '0;
        end
    end

endmodule

// File: tb/tb_beta_mem_stall.sv
// -----------------------------------------------------------------------------
// tb_beta_mem_stall
//
// Self-checking bench for beta_mem_stall (W=32, MAX_WAIT=15). Expected load
// data is pushed to a queue whenever an instruction is made to retire and
// popped when rdout is sampled after the edge.
// -----------------------------------------------------------------------------
module tb_beta_mem_stall;

    localparam int W        = 32;
    localparam int MAX_WAIT = 15;

    localparam logic [31:0] NOP_W = 32'h83FF_FFFF;
    localparam logic [31:0] BNE_W = 32'h7BDF_FFFF;
    localparam logic [31:0] LD_W  = {6'b011000, 26'h0001_234};
    localparam logic [31:0] LDR_W = {6'b011111, 26'h0002_345};
    localparam logic [31:0] ST_W  = {6'b011001, 26'h0003_456};
    localparam logic [31:0] ADD_W = {6'b100000, 26'h0004_567};

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   irsrc;
    logic [W-1:0] pcin, irin, yin, din;
    logic [W-1:0] pcout, irout, yout, rdout, maddr, mwd;
    logic         mwr, moe, mack, stall, merr;
    logic [W-1:0] mrd;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_rd_q[$];
    logic [W-1:0] exp_rd;

    beta_mem_stall #(.W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .irsrc (irsrc),
        .pcin  (pcin),
        .irin  (irin),
        .yin   (yin),
        .din   (din),
        .pcout (pcout),
        .irout (irout),
        .yout  (yout),
        .rdout (rdout),
        .maddr (maddr),
        .mwd   (mwd),
        .mwr   (mwr),
        .moe   (moe),
        .mack  (mack),
        .mrd   (mrd),
        .stall (stall),
        .merr  (merr)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irsrc = 2'd0; irin = LD_W; pcin = 32'h4;
        yin = 32'h40; din = '0; mack = 1'b0; mrd = '0;
        tick();
        tick();
        n_vec++;
        if (irout !== NOP_W) begin n_err++; $display("FAIL reset_ir: got %h want %h", irout, NOP_W); end
        n_vec++;
        if ({mwr, moe, stall, merr} !== 4'b0000) begin n_err++; $display("FAIL reset_strobes: got %b want 0000", {mwr, moe, stall, merr}); end
        n_vec++;
        if ({pcout, yout, rdout, maddr, mwd} !== '0) begin n_err++; $display("FAIL reset_regs: pc %h y %h rd %h addr %h wd %h want all 0", pcout, yout, rdout, maddr, mwd); end

        reset = 1'b0;
        tick();
        n_vec++;
        if (irout !== LD_W || moe !== 1'b1 || pcout !== 32'h4) begin
            n_err++; $display("FAIL reset_first_adv: ir %h moe %b pc %h want %h 1 4", irout, moe, pcout, LD_W);
        end

        // Complete that load so the next test starts from a NOP.
        mack = 1'b1; mrd = 32'h1111_1111; irin = NOP_W;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_ld_ack_stall: got %b want 0", stall); end
        exp_rd_q.push_back(32'h1111_1111);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL reset_ld_rd: got %h want %h", rdout, exp_rd); end
    endtask

    task automatic test_ld_zero_wait();
        // mack is already high when the LD arrives: the NOP retiring at this
        // edge must ignore it.
        irin = LD_W; yin = 32'h40; pcin = 32'h100; mack = 1'b1; mrd = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL ld0_pre_stall: got %b want 0", stall); end
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL ld0_nop_rd: got %h want %h", rdout, exp_rd); end
        n_vec++;
        if (irout !== LD_W || maddr !== 32'h40 || moe !== 1'b1 || stall !== 1'b0) begin
            n_err++; $display("FAIL ld0_issue: ir %h addr %h moe %b stall %b", irout, maddr, moe, stall);
        end
        irin = NOP_W;
        exp_rd_q.push_back(32'hDEAD_BEEF);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd || irout !== NOP_W) begin
            n_err++; $display("FAIL ld0_rd: rd %h ir %h want %h %h", rdout, irout, exp_rd, NOP_W);
        end
    endtask

    task automatic test_st_wait3();
        irin = ST_W; yin = 32'h80; din = 32'h1234; pcin = 32'h200; mack = 1'b0;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL st_prev_rd: got %h want %h", rdout, exp_rd); end

        pcin = 32'h999; irin = ADD_W; yin = 32'h555; din = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (stall !== 1'b1 || mwr !== 1'b1 || maddr !== 32'h80 || mwd !== 32'h1234) begin
                n_err++; $display("FAIL st_wait_c%0d: stall %b mwr %b addr %h wd %h want 1 1 80 1234", i, stall, mwr, maddr, mwd);
            end
            tick();
            n_vec++;
            if (pcout !== 32'h200 || irout !== ST_W || yout !== 32'h80) begin
                n_err++; $display("FAIL st_hold_c%0d: pc %h ir %h y %h", i, pcout, irout, yout);
            end
        end
        mack = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b0 || mwr !== 1'b1 || merr !== 1'b0) begin
            n_err++; $display("FAIL st_ack: stall %b mwr %b merr %b want 0 1 0", stall, mwr, merr);
        end
        exp_rd_q.push_back('0);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd || irout !== ADD_W || pcout !== 32'h999 || mwr !== 1'b0) begin
            n_err++; $display("FAIL st_retire: rd %h ir %h pc %h mwr %b", rdout, irout, pcout, mwr);
        end
    endtask

    task automatic test_timeout();
        irin = LD_W; yin = 32'h300; mack = 1'b0; mrd = 32'hFFFF_FFFF;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL to_prev_rd: got %h want %h", rdout, exp_rd); end
        irin = NOP_W;
        for (int c = 0; c < MAX_WAIT; c++) begin
            #1;
            n_vec++;
            if (stall !== 1'b1 || merr !== 1'b0) begin
                n_err++; $display("FAIL to_wait_c%0d: stall %b merr %b want 1 0", c, stall, merr);
            end
            tick();
        end
        n_vec++;
        if (stall !== 1'b0 || merr !== 1'b1 || moe !== 1'b1) begin
            n_err++; $display("FAIL to_abort: stall %b merr %b moe %b want 0 1 1", stall, merr, moe);
        end
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd || merr !== 1'b0 || irout !== NOP_W) begin
            n_err++; $display("FAIL to_retire: rd %h merr %b ir %h", rdout, merr, irout);
        end
    endtask

    task automatic test_irsrc();
        irin = ST_W; yin = 32'h90; din = 32'h5; mack = 1'b0;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL irs_prev_rd: got %h want %h", rdout, exp_rd); end
        irsrc = 2'd1; irin = ADD_W;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (stall !== 1'b1) begin n_err++; $display("FAIL irs_stall_c%0d: got %b want 1", i, stall); end
            tick();
            n_vec++;
            if (irout !== ST_W) begin n_err++; $display("FAIL irs_hold_c%0d: got %h want %h", i, irout, ST_W); end
        end
        mack = 1'b1;
        #1;
        exp_rd_q.push_back('0);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (irout !== BNE_W || rdout !== exp_rd) begin
            n_err++; $display("FAIL irs_bne: ir %h rd %h want %h %h", irout, rdout, BNE_W, exp_rd);
        end
        irsrc = 2'd2;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (irout !== NOP_W || rdout !== exp_rd) begin
            n_err++; $display("FAIL irs_nop: ir %h rd %h want %h %h", irout, rdout, NOP_W, exp_rd);
        end
        irsrc = 2'd0;
    endtask

    task automatic test_back_to_back();
        // LDR acknowledged immediately, then LD that must wait afresh.
        irin = LDR_W; mack = 1'b1; mrd = 32'hA5A5_A5A5;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd || moe !== 1'b1 || stall !== 1'b0) begin
            n_err++; $display("FAIL b2b_ldr: rd %h moe %b stall %b", rdout, moe, stall);
        end
        irin = LD_W; mrd = 32'h0BAD_F00D;
        exp_rd_q.push_back(32'h0BAD_F00D);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL b2b_ldr_rd: got %h want %h", rdout, exp_rd); end
        #1;
        n_vec++;
        if (stall !== 1'b1 || irout !== LD_W) begin
            n_err++; $display("FAIL b2b_ld_fresh: stall %b ir %h want 1 %h", stall, irout, LD_W);
        end
        tick();
        mack = 1'b1; mrd = 32'h1234_5678; irin = NOP_W;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_ld_ack: got %b want 0", stall); end
        exp_rd_q.push_back(32'h1234_5678);
        tick();
        mack = 1'b0;
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL b2b_ld_rd: got %h want %h", rdout, exp_rd); end
    endtask

    task automatic test_reset_mid_wait();
        irin = LD_W; mack = 1'b0;
        exp_rd_q.push_back('0);
        tick();
        exp_rd = exp_rd_q.pop_front();
        n_vec++;
        if (rdout !== exp_rd) begin n_err++; $display("FAIL rmw_prev_rd: got %h want %h", rdout, exp_rd); end
        irin = NOP_W;
        tick();
        tick();
        tick();
        n_vec++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL rmw_in_wait: got %b want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (stall !== 1'b0 || merr !== 1'b0 || irout !== NOP_W || moe !== 1'b0 || rdout !== '0) begin
            n_err++; $display("FAIL rmw_after: stall %b merr %b ir %h moe %b rd %h", stall, merr, irout, moe, rdout);
        end
        n_vec++;
        if (dut.cnt !== '0) begin n_err++; $display("FAIL rmw_cnt: got %0d want 0", dut.cnt); end
    endtask

    initial begin
        test_reset();
        test_ld_zero_wait();
        test_st_wait3();
        test_timeout();
        test_irsrc();
        test_back_to_back();
        test_reset_mid_wait();
        n_vec++;
        if (exp_rd_q.size() != 0) begin n_err++; $display("FAIL sb_drain: %0d entries left want 0", exp_rd_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
